pea_psum_acc: RTL and testbench
===============================

# pea_psum_acc

Accumulates partial sums from the PE array across input-channel passes and streams completed output-channel tiles downstream. Sits directly downstream of the PE-array controller: it consumes that controller's `pvalid`, `ic_done` and `oc_done` together with the array's per-row psums. It holds two ping-pong banks so accumulation of the next output channel overlaps draining of the previous one.

## Interface
- `COL`, 8: PE rows per column beat (lanes).
- `TILE_LEN`, 16: max column positions per tile pass.
- `PSUM_WIDTH`, 24: signed psum width per lane.
- `ACC_WIDTH`, 32: signed accumulator / output width per lane.
- `PV_LAT`, 3: cycles from `ic_done`/`oc_done` to the matching last `pvalid` beat.
- `clk` in 1: clock. One clock domain only.
- `rstn` in 1: reset, synchronous, active-low.
- `pvalid` in COL: per-row psum valid, from the controller.
- `psum` in COL*PSUM_WIDTH: lane r at bits [r*PSUM_WIDTH +: PSUM_WIDTH].
- `ic_done` in 1: pass end, from the controller, undelayed.
- `oc_done` in 1: output channel end, from the controller, undelayed.
- `out_valid` out 1: drain beat valid.
- `out_ready` in 1: downstream accept.
- `out_data` out COL*ACC_WIDTH: one accumulated column, packed in the same lane order as `psum`.
- `out_mask` out COL: rows valid in this column.
- `out_last` out 1: final column of the tile.
- `ovf_err` out 1: sticky. Set when a tile completes while no bank is free.
- `busy` out 1: any bank in ACC (with at least one beat written) or FULL.

## Operation
- `ic_done` and `oc_done` are each delayed PV_LAT cycles internally, giving `ic_end_d` and `oc_end_d`. These align with the last `pvalid` beat of a pass.
- Beat: any cycle with `|pvalid`.
- Write pointer `wp` (log2 TILE_LEN bits):
  - increments per beat;
  - cleared on `ic_end_d`;
  - does not wrap within a pass. A beat at `wp==TILE_LEN-1` without `ic_end_d` saturates `wp`.
- Bank states are FREE, ACC and FULL. Reset leaves bank0=ACC and bank1=FREE.
- Accumulation into the ACC bank, for each row r with `pvalid[r]`:
  - if `first_pass`: `acc[wp][r] = sext(psum_r)`;
  - otherwise: `acc[wp][r] += sext(psum_r)`;
  - arithmetic is two's-complement wrap at ACC_WIDTH;
  - `mask[wp][r]` is OR-ed with `pvalid[r]`, and cleared when `first_pass` is set.
- `first_pass`:
  - set at reset and on `oc_end_d`;
  - cleared on `ic_end_d` without `oc_end_d`.
- Column count: on the first pass, `ncol` latches `wp+1` at the `ic_end_d` beat.
- On `oc_end_d`:
  - the ACC bank becomes FULL;
  - if the other bank is FREE, it becomes ACC;
  - if the other bank is FULL (still draining), `ovf_err` is set, the completed bank is discarded (stays ACC), and accumulation restarts into it.
- Drain FSM:
  - IDLE → DRAIN when a FULL bank exists; `rp` is set to 0.
  - In DRAIN, each `out_valid & out_ready` advances `rp`.
  - `out_last` is asserted when `rp==ncol-1`.
  - The accepted last beat makes the bank FREE and returns the FSM to IDLE.
- Simultaneous `oc_end_d` and last drain handshake: the draining bank frees first, so the swap succeeds and `ovf_err` is not set.
- Reset mid-operation discards all bank contents and returns to the reset state.

## Timing
- Accumulate write is registered; it lands on the edge ending the beat cycle.
- `out_valid` rises 1 cycle after the `oc_end_d` cycle, i.e. PV_LAT+1 after `oc_done`.
- Handshake rules:
  - `out_valid`, `out_data`, `out_mask` and `out_last` hold stable until accepted;
  - `out_valid` never drops without a handshake;
  - with `out_ready` high, one beat per cycle;
  - back-to-back tiles are separated by 1 IDLE cycle.
- Reset values: `out_valid`=0, `out_data`=0, `out_mask`=0, `out_last`=0, `ovf_err`=0, `busy`=0. `out_*` payload is forced to 0 while `out_valid`=0.

## Structure
- Package `pea_pkg` holds:
  - `bank_state_e` (FREE/ACC/FULL);
  - `drain_state_e` (IDLE/DRAIN);
  - default ACC_WIDTH and PV_LAT constants;
  - the psum lane slicing function.
- Sub-module `pea_psum_bank`: TILE_LEN×COL accumulator registers plus mask, with write/accumulate port and combinational read port. It is instantiated twice.
- Top level holds the delay lines, pointers, bank states and drain FSM.

## Test plan
- Single pass, 16 beats, all lanes `psum`=1, with `ic_done`+`oc_done` on the last pass → 16 drain beats, every lane 1, `out_mask`=8'hFF, `out_last` on beat 15.
- Three passes, `psum` lane r = r−3 (signed) → every output lane equals 3·(r−3); lane 0 = −9.
- Last pass with `pvalid`=8'h1F and only 10 columns → `ncol`=10, `out_mask`=8'h1F, `out_last` on beat 9.
- `out_ready` toggling 1/0 during drain while the next tile accumulates → payload stable while stalled, second tile drains correctly, `ovf_err`=0.
- `out_ready`=0 held across two tile completions → second tile dropped, `ovf_err`=1 sticky, first tile still drains intact.
- `rstn` low for 1 cycle mid-drain → `out_valid`=0 the next cycle, `busy`=0, and a fresh tile then accumulates from zero.

Source files
------------

// File: rtl/pea_psum_acc_pkg.sv
// Shared types and helpers for the psum accumulator.
//   bank_state_e  : ping-pong bank ownership (FREE / ACC / FULL)
//   drain_state_e : output drain FSM states
//   psum_lane     : extracts one lane from a packed psum bus, sign-extended
package pea_pkg;

   typedef enum logic [1:0] {
      BANK_FREE = 2'd0,
      BANK_ACC  = 2'd1,
      BANK_FULL = 2'd2
   } bank_state_e;

   typedef enum logic [0:0] {
      DR_IDLE  = 1'b0,
      DR_DRAIN = 1'b1
   } drain_state_e;

   localparam int unsigned DEF_ACC_WIDTH = 32;
   localparam int unsigned DEF_PV_LAT    = 3;

   // Upper bounds for the generic slicing helper below.
   localparam int unsigned LANE_MAXW = 64;
   localparam int unsigned BUS_MAXW  = 1024;

   // Lane idx of width w, sign-extended to LANE_MAXW bits. The shift pair
   // performs the sign extension without a variable bit index.
   function automatic logic signed [LANE_MAXW-1:0] psum_lane(
      input logic [BUS_MAXW-1:0] bus,
      input int unsigned         idx,
      input int unsigned         w
   );
      logic signed [LANE_MAXW-1:0] t;
      t = signed'(LANE_MAXW'(bus >> (idx * w)));
      t = t <<< (LANE_MAXW - w);
      t = t >>> (LANE_MAXW - w);
      return t;
   endfunction

endpackage

// File: rtl/pea_psum_acc_bank.sv
// One accumulator bank: TILE_LEN columns x COL lanes plus per-column lane mask.
//   clk_i, rstn_i   : clock, synchronous active-low reset (clears contents)
//   wr_en_i         : write/accumulate strobe for column wr_addr_i
//   wr_first_i      : overwrite instead of accumulate; mask restarts
//   wr_valid_i      : per-lane write enable
//   wr_psum_i       : packed signed psums, lane r at [r*PSUM_WIDTH +: PSUM_WIDTH]
//   rd_addr_i       : combinational read column
//   rd_data_o       : packed accumulators, lane r at [r*ACC_WIDTH +: ACC_WIDTH]
//   rd_mask_o       : lanes written in the read column
module pea_psum_bank
   import pea_pkg::*;
#(
   parameter int unsigned COL        = 8,
   parameter int unsigned TILE_LEN   = 16,
   parameter int unsigned PSUM_WIDTH = 24,
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int unsigned AW         = 4
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      wr_en_i,
   input  logic                      wr_first_i,
   input  logic [AW-1:0]             wr_addr_i,
   input  logic [COL-1:0]            wr_valid_i,
   input  logic [COL*PSUM_WIDTH-1:0] wr_psum_i,
   input  logic [AW-1:0]             rd_addr_i,
   output logic [COL*ACC_WIDTH-1:0]  rd_data_o,
   output logic [COL-1:0]            rd_mask_o
);

   logic [ACC_WIDTH-1:0] acc_q  [TILE_LEN][COL];
   logic [COL-1:0]       mask_q [TILE_LEN];
   logic [ACC_WIDTH-1:0] lane_c [COL];

   always_comb begin
      for (int unsigned r = 0; r < COL; r++) begin
         lane_c[r] = ACC_WIDTH'(psum_lane(BUS_MAXW'(wr_psum_i), r, PSUM_WIDTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int unsigned t = 0; t < TILE_LEN; t++) begin
            mask_q[t] <= '0;
            for (int unsigned r = 0; r < COL; r++) begin
               acc_q[t][r] <= '0;
            end
         end
      end else if (wr_en_i) begin
         for (int unsigned r = 0; r < COL; r++) begin
            if (wr_valid_i[r]) begin
               acc_q[wr_addr_i][r] <= wr_first_i ? lane_c[r]
                                                 : acc_q[wr_addr_i][r] + lane_c[r];
            end
         end
         mask_q[wr_addr_i] <= wr_first_i ? wr_valid_i : (mask_q[wr_addr_i] | wr_valid_i);
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int unsigned r = 0; r < COL; r++) begin
         rd_data_o[r*ACC_WIDTH +: ACC_WIDTH] = acc_q[rd_addr_i][r];
      end
      rd_mask_o = mask_q[rd_addr_i];
   end

endmodule

// File: rtl/pea_psum_acc.sv
// Partial-sum accumulator with two ping-pong banks and a streaming drain port.
//   clk, rstn          : clock, synchronous active-low reset
//   pvalid, psum       : per-lane psum beats from the PE array
//   ic_done, oc_done   : pass / output-channel end, PV_LAT ahead of last beat
//   out_valid/ready    : drain handshake
//   out_data, out_mask : one accumulated column and its valid lanes
//   out_last           : final column of the tile
//   ovf_err            : sticky, tile completed with no free bank
//   busy               : a bank holds accumulated or pending data
module pea_psum_acc
   import pea_pkg::*;
#(
   parameter int unsigned COL        = 8,
   parameter int unsigned TILE_LEN   = 16,
   parameter int unsigned PSUM_WIDTH = 24,
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int unsigned PV_LAT     = DEF_PV_LAT
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [COL-1:0]            pvalid,
   input  logic [COL*PSUM_WIDTH-1:0] psum,
   input  logic                      ic_done,
   input  logic                      oc_done,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COL*ACC_WIDTH-1:0]  out_data,
   output logic [COL-1:0]            out_mask,
   output logic                      out_last,
   output logic                      ovf_err,
   output logic                      busy
);

   localparam int unsigned AW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

   logic [PV_LAT-1:0] ic_sr_q, oc_sr_q;
   logic              ic_end_d, oc_end_d;
   logic              beat;

   logic [AW-1:0]     wp_q, wp_d;
   logic              first_q, first_d;
   logic              acc_sel_q, acc_sel_d;
   bank_state_e       st_q [2];
   bank_state_e       st_d [2];
   logic [AW:0]       ncol_q [2];
   logic [AW:0]       ncol_d [2];
   logic              wrote_q, wrote_d;
   logic              ovf_q, ovf_d;
   drain_state_e      dst_q, dst_d;
   logic              drain_sel_q, drain_sel_d;
   logic [AW-1:0]     rp_q, rp_d;

   logic              other, other_free, rp_last, hs, drain_done;
   logic [COL*ACC_WIDTH-1:0] rd_data_b [2];
   logic [COL-1:0]           rd_mask_b [2];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ic_sr_q <= '0;
         oc_sr_q <= '0;
      end else begin
         ic_sr_q[0] <= ic_done;
         oc_sr_q[0] <= oc_done;
         for (int unsigned i = 1; i < PV_LAT; i++) begin
            ic_sr_q[i] <= ic_sr_q[i-1];
            oc_sr_q[i] <= oc_sr_q[i-1];
         end
      end
   end

   assign ic_end_d = ic_sr_q[PV_LAT-1];
   assign oc_end_d = oc_sr_q[PV_LAT-1];
   assign beat     = |pvalid;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pea_psum_bank #(
         .COL        (COL),
         .TILE_LEN   (TILE_LEN),
         .PSUM_WIDTH (PSUM_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH),
         .AW         (AW)
      ) u_bank (
         .clk_i      (clk),
         .rstn_i     (rstn),
         .wr_en_i    (beat && (acc_sel_q == 1'(b))),
         .wr_first_i (first_q),
         .wr_addr_i  (wp_q),
         .wr_valid_i (pvalid),
         .wr_psum_i  (psum),
         .rd_addr_i  (rp_q),
         .rd_data_o  (rd_data_b[b]),
         .rd_mask_o  (rd_mask_b[b])
      );
   end

   assign out_valid  = (dst_q == DR_DRAIN);
   assign hs         = out_valid && out_ready;
   // Second term bounds the drain even if ncol was never latched.
   assign rp_last    = ({1'b0, rp_q} == (ncol_q[drain_sel_q] - 1'b1)) ||
                       (rp_q == AW'(TILE_LEN - 1));
   assign drain_done = hs && rp_last;
   assign other      = ~acc_sel_q;
   // A bank finishing its drain this cycle counts as free for the swap.
   assign other_free = (st_q[other] == BANK_FREE) || (drain_done && (drain_sel_q == other));

   always_comb begin
      wp_d = wp_q;
      if (ic_end_d) begin
         wp_d = '0;
      end else if (beat && (wp_q != AW'(TILE_LEN - 1))) begin
         wp_d = wp_q + 1'b1;
      end

      first_d = first_q;
      if (oc_end_d) begin
         first_d = 1'b1;
      end else if (ic_end_d) begin
         first_d = 1'b0;
      end

      ncol_d = ncol_q;
      if (ic_end_d && first_q) begin
         ncol_d[acc_sel_q] = {1'b0, wp_q} + 1'b1;
      end

      st_d      = st_q;
      acc_sel_d = acc_sel_q;
      ovf_d     = ovf_q;
      wrote_d   = wrote_q || beat;
      if (drain_done) begin
         st_d[drain_sel_q] = BANK_FREE;
      end
      if (oc_end_d) begin
         wrote_d = 1'b0;
         if (other_free) begin
            st_d[acc_sel_q] = BANK_FULL;
            st_d[other]     = BANK_ACC;
            acc_sel_d       = other;
         end else begin
            ovf_d = 1'b1;
         end
      end

      dst_d       = dst_q;
      rp_d        = rp_q;
      drain_sel_d = drain_sel_q;
      case (dst_q)
         DR_IDLE: begin
            // Enter on the completing edge itself so out_valid appears the
            // cycle after oc_end_d rather than one later.
            if (st_q[other] == BANK_FULL) begin
               dst_d       = DR_DRAIN;
               rp_d        = '0;
               drain_sel_d = other;
            end else if (oc_end_d && (st_q[other] == BANK_FREE)) begin
               dst_d       = DR_DRAIN;
               rp_d        = '0;
               drain_sel_d = acc_sel_q;
            end
         end
         DR_DRAIN: begin
            if (hs) begin
               if (rp_last) begin
                  dst_d = DR_IDLE;
               end else begin
                  rp_d = rp_q + 1'b1;
               end
            end
         end
         default: dst_d = DR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wp_q        <= '0;
         first_q     <= 1'b1;
         acc_sel_q   <= 1'b0;
         st_q[0]     <= BANK_ACC;
         st_q[1]     <= BANK_FREE;
         ncol_q[0]   <= '0;
         ncol_q[1]   <= '0;
         wrote_q     <= 1'b0;
         ovf_q       <= 1'b0;
         dst_q       <= DR_IDLE;
         drain_sel_q <= 1'b0;
         rp_q        <= '0;
      end else begin
         wp_q        <= wp_d;
         first_q     <= first_d;
         acc_sel_q   <= acc_sel_d;
         st_q        <= st_d;
         ncol_q      <= ncol_d;
         wrote_q     <= wrote_d;
         ovf_q       <= ovf_d;
         dst_q       <= dst_d;
         drain_sel_q <= drain_sel_d;
         rp_q        <= rp_d;
      end
   end

   assign out_data = out_valid ? rd_data_b[drain_sel_q] : '0;
   assign out_mask = out_valid ? rd_mask_b[drain_sel_q] : '0;
   assign out_last = out_valid && rp_last;
   assign ovf_err  = ovf_q;
   assign busy     = wrote_q || (st_q[0] == BANK_FULL) || (st_q[1] == BANK_FULL);

endmodule

// File: tb/tb_pea_psum_acc.sv
// Scoreboard bench for pea_psum_acc: tiles are issued as directed passes,
// expected drain beats are queued at issue time and checked by a monitor.
module tb_pea_psum_acc;

   localparam int COL    = 8;
   localparam int TILE   = 16;
   localparam int PSUM_W = 24;
   localparam int ACC_W  = 32;
   localparam int PVL    = 3;
   localparam int DW     = COL * ACC_W;

   typedef struct {
      logic [DW-1:0]  data;
      logic [COL-1:0] mask;
      logic           last;
   } exp_t;

   logic                  clk;
   logic                  rstn;
   logic [COL-1:0]        pvalid;
   logic [COL*PSUM_W-1:0] psum;
   logic                  ic_done, oc_done;
   logic                  out_valid, out_ready;
   logic [DW-1:0]         out_data;
   logic [COL-1:0]        out_mask;
   logic                  out_last, ovf_err, busy;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   rmode = 0;  // 0: ready high, 1: toggle, 2: ready low

   pea_psum_acc #(
      .COL        (COL),
      .TILE_LEN   (TILE),
      .PSUM_WIDTH (PSUM_W),
      .ACC_WIDTH  (ACC_W),
      .PV_LAT     (PVL)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .pvalid    (pvalid),
      .psum      (psum),
      .ic_done   (ic_done),
      .oc_done   (oc_done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_last  (out_last),
      .ovf_err   (ovf_err),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
         endcase
      end
   end

   function automatic logic [DW-1:0] lane_mask(input logic [DW-1:0] d, input logic [COL-1:0] m);
      for (int r = 0; r < COL; r++) begin
         if (!m[r]) d[r*ACC_W +: ACC_W] = '0;
      end
      return d;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, want);
      end
   endtask

   task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Expected beats: lane r of column c = p * (a + b*r + cs*c); unmasked lanes zero.
   task automatic push_tile(input int ncols, input logic [COL-1:0] m, input int p,
                            input int a, input int b, input int cs);
      exp_t e;
      for (int c = 0; c < ncols; c++) begin
         e.data = '0;
         for (int r = 0; r < COL; r++) begin
            if (m[r]) e.data[r*ACC_W +: ACC_W] = ACC_W'(p * (a + b*r + cs*c));
         end
         e.mask = m;
         e.last = (c == ncols - 1);
         exp_q.push_back(e);
      end
   endtask

   // One pass of ncols consecutive beats; done pulses lead the last beat by PVL.
   task automatic run_pass(input int ncols, input logic [COL-1:0] pv, input int a,
                           input int b, input int cs, input bit last_pass);
      for (int c = 0; c < ncols; c++) begin
         @(posedge clk);
         #1;
         pvalid = pv;
         for (int r = 0; r < COL; r++) begin
            psum[r*PSUM_W +: PSUM_W] = PSUM_W'(a + b*r + cs*c);
         end
         ic_done = (c == ncols - 1 - PVL);
         oc_done = last_pass && (c == ncols - 1 - PVL);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      pvalid  = '0;
      psum    = '0;
      ic_done = 1'b0;
      oc_done = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0 || out_valid) begin
         bad++;
         $display("FAIL %s_drain: %0d beats pending, out_valid=%b, want 0 pending",
                  nm, exp_q.size(), out_valid);
      end
   endtask

   // Monitor: scoreboard pop on handshake, plus hold-stability after a stall.
   initial begin
      exp_t           e;
      logic           stall_p;
      logic [DW-1:0]  hd;
      logic [COL-1:0] hm;
      logic           hl;
      stall_p = 1'b0;
      hd = '0;
      hm = '0;
      hl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            stall_p = 1'b0;
         end else begin
            if (stall_p) begin
               total++;
               if (!(out_valid && out_data == hd && out_mask == hm && out_last == hl)) begin
                  bad++;
                  $display("FAIL hold: got v=%b data=%h mask=%h last=%b, want v=1 data=%h mask=%h last=%b",
                           out_valid, out_data, out_mask, out_last, hd, hm, hl);
               end
            end
            if (out_valid && out_ready) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL extra_beat: got data=%h mask=%h, want no beat", out_data, out_mask);
               end else begin
                  e = exp_q.pop_front();
                  if (lane_mask(out_data, e.mask) !== e.data || out_mask !== e.mask ||
                      out_last !== e.last) begin
                     bad++;
                     $display("FAIL beat: got data=%h mask=%h last=%b, want data=%h mask=%h last=%b",
                              lane_mask(out_data, e.mask), out_mask, out_last, e.data, e.mask, e.last);
                  end
               end
            end
            stall_p = out_valid && !out_ready;
            hd = out_data;
            hm = out_mask;
            hl = out_last;
         end
      end
   end

   initial begin
      int n;
      rstn    = 1'b0;
      pvalid  = '0;
      psum    = '0;
      ic_done = 1'b0;
      oc_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_out_data", out_data, '0);
      chk1("rst_out_mask", |out_mask, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_ovf_err", ovf_err, 1'b0);
      chk1("rst_busy", busy, 1'b0);

      // Single pass, all ones.
      push_tile(16, 8'hFF, 1, 1, 0, 0);
      run_pass(16, 8'hFF, 1, 0, 0, 1'b1);
      chk1("t1_busy", busy, 1'b1);
      idle();
      wait_drain("t1");

      // Three passes of signed lane values r-3.
      push_tile(16, 8'hFF, 3, -3, 1, 0);
      run_pass(16, 8'hFF, -3, 1, 0, 1'b0);
      run_pass(16, 8'hFF, -3, 1, 0, 1'b0);
      run_pass(16, 8'hFF, -3, 1, 0, 1'b1);
      idle();
      wait_drain("t2");

      // Short tile, partial lane mask.
      push_tile(10, 8'h1F, 1, 100, -7, 2);
      run_pass(10, 8'h1F, 100, -7, 2, 1'b1);
      idle();
      wait_drain("t3");

      // Toggling ready while the next tile accumulates.
      rmode = 1;
      push_tile(12, 8'hFF, 1, 5, 2, -1);
      run_pass(12, 8'hFF, 5, 2, -1, 1'b1);
      push_tile(16, 8'hFF, 2, -1000, 3, 7);
      run_pass(16, 8'hFF, -1000, 3, 7, 1'b0);
      run_pass(16, 8'hFF, -1000, 3, 7, 1'b1);
      idle();
      wait_drain("t4");
      chk1("t4_ovf_err", ovf_err, 1'b0);

      // Two completions with ready held low: second tile is dropped.
      rmode = 2;
      push_tile(16, 8'hFF, 1, 7, 1, 0);
      run_pass(16, 8'hFF, 7, 1, 0, 1'b1);
      run_pass(16, 8'hFF, 9, 0, 0, 1'b1);
      idle();
      repeat (4) @(posedge clk);
      #1;
      chk1("t5_ovf_err", ovf_err, 1'b1);
      chk1("t5_out_valid", out_valid, 1'b1);
      chk1("t5_busy", busy, 1'b1);
      rmode = 0;
      wait_drain("t5");
      chk1("t5_ovf_sticky", ovf_err, 1'b1);

      // Reset in the middle of a drain.
      push_tile(16, 8'hFF, 1, 2, 0, 0);
      run_pass(16, 8'hFF, 2, 0, 0, 1'b1);
      idle();
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk1("t6_drain_started", out_valid, 1'b1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk1("t6_out_valid", out_valid, 1'b0);
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_ovf_err", ovf_err, 1'b0);
      chkw("t6_out_data", out_data, '0);
      chk1("t6_out_last", out_last, 1'b0);

      // Fresh tile after reset must start from zero.
      push_tile(16, 8'hFF, 2, 4, -1, 3);
      run_pass(16, 8'hFF, 4, -1, 3, 1'b0);
      run_pass(16, 8'hFF, 4, -1, 3, 1'b1);
      idle();
      wait_drain("t6_fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
